// File: rtl/seq_div32_pkg.sv
// Shared definitions for the seq_div32 restoring divider: state encoding,
// default width and the most-negative constant.
package seq_div32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam logic [DEF_WIDTH-1:0] MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract |B| at
// WIDTH+1 bits, keep the difference and set Q[0] when it is non-negative.
module seq_div_step
    import seq_div32_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    // R < |B| always holds, so the difference fits WIDTH+1 bits and its MSB is a true sign.
    always_comb begin
        r_sh  = {r_in, q_in[WIDTH-1]};
        trial = r_sh - {1'b0, b_mag};
        if (!trial[WIDTH]) begin
            r_out = trial[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = r_sh[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle signed/unsigned restoring divider behind a valid/ready handshake.
// Define SEQ_DIV_EARLY_EN to finish in one cycle when |A| < |B|.
module seq_div32
    import seq_div32_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dzflag,
    output logic             ovflag
);

    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, bmag_q, bmag_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             negq_q, negq_d, negr_q, negr_d, ovp_q, ovp_d;
    logic             dz_q, dz_d, ov_q, ov_d;
    logic [WIDTH-1:0] abs_a, abs_b, step_r, step_q;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .b_mag (bmag_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        bmag_d  = bmag_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        ovp_d   = ovp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        abs_a   = (sgn && A[WIDTH-1]) ? -A : A;
        abs_b   = (sgn && B[WIDTH-1]) ? -B : B;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dz_d = 1'b0;
                    ov_d = 1'b0;
                    if (B == '0) begin
                        quo_d   = '1;
                        rem_d   = A;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`ifdef SEQ_DIV_EARLY_EN
                    else if (abs_a < abs_b) begin
                        quo_d   = '0;
                        rem_d   = A;
                        state_d = DONE;
                    end
`endif
                    else begin
                        r_d     = '0;
                        q_d     = abs_a;
                        bmag_d  = abs_b;
                        negq_d  = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        negr_d  = sgn & A[WIDTH-1];
                        ovp_d   = sgn && (A == MIN_W) && (B == '1);
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            // MIN / -1 needs no special case: Q = 2^(WIDTH-1), negq = 0, R = 0.
            FIX: begin
                quo_d   = negq_q ? -q_q : q_q;
                rem_d   = negr_q ? -r_q : r_q;
                ov_d    = ovp_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            bmag_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            ovp_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            bmag_q  <= bmag_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            ovp_q   <= ovp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quo       = quo_q;
    assign rem       = rem_q;
    assign dzflag    = dz_q;
    assign ovflag    = ov_q;

endmodule

// File: tb/tb_seq_div32.sv
// Randomized self-checking bench for seq_div32 against an arithmetic model
// (native / and % on 64-bit signed values); honours SEQ_DIV_EARLY_EN for latency.
module tb_seq_div32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sgn, out_valid, out_ready, dzflag, ovflag;
    logic [31:0] A, B, quo, rem;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
        logic        ov;
        logic [31:0] lat;
    } res_t;

    res_t        exp_r;
    logic        cur_s;
    logic [31:0] cur_a, cur_b;

    seq_div32 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sgn(sgn), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .quo(quo), .rem(rem), .dzflag(dzflag), .ovflag(ovflag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb;
        logic [31:0] ma, mb;
        r.dz  = (b == 32'd0);
        r.ov  = s && (a == seq_div32_pkg::MIN) && (b == 32'hFFFF_FFFF);
        r.lat = 32'd34;
        if (b == 32'd0) begin
            r.quo = 32'hFFFF_FFFF;
            r.rem = a;
            r.lat = 32'd1;
            return r;
        end
        if (s) begin
            sa    = $signed(a);
            sb    = $signed(b);
            r.quo = 32'(sa / sb);
            r.rem = 32'(sa % sb);
        end else begin
            r.quo = a / b;
            r.rem = a % b;
        end
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
`ifdef SEQ_DIV_EARLY_EN
        if (ma < mb) r.lat = 32'd1;
`else
        if (ma < mb) r.lat = 32'd34;
`endif
        return r;
    endfunction

    // Every cycle a result is presented it must match the model and obey the identity.
    always @(negedge clk) begin
        logic [31:0] rm, bm;
        if (!rst && out_valid) begin
            chk("quo", quo, exp_r.quo);
            chk("rem", rem, exp_r.rem);
            chk("dzflag", 32'(dzflag), 32'(exp_r.dz));
            chk("ovflag", 32'(ovflag), 32'(exp_r.ov));
            if (cur_b != 32'd0) begin
                chk("identity", quo * cur_b + rem, cur_a);
                rm = (cur_s && rem[31]) ? -rem : rem;
                bm = (cur_s && cur_b[31]) ? -cur_b : cur_b;
                chk("rem_bound", 32'(rm < bm), 32'd1);
            end
        end
    end

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int bp);
        int lat;
        exp_r     = model(s, a, b);
        cur_s     = s;
        cur_a     = a;
        cur_b     = b;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        sgn       = s;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), exp_r.lat);
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                sgn = 1'b0; A = 32'd5; B = 32'd1; in_valid = 1'b1;
                @(posedge clk); #1;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        res_t m;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sgn = 1'b0; A = '0; B = '0;
        cur_s = 1'b0; cur_a = '0; cur_b = '0; exp_r = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quo", quo, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_flags", {30'd0, dzflag, ovflag}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        m = model(1'b0, 32'd100, 32'd7);
        chk("mdl_100_7_q", m.quo, 32'd14);
        chk("mdl_100_7_r", m.rem, 32'd2);
        m = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("mdl_m7_2_q", m.quo, 32'hFFFF_FFFD);
        chk("mdl_m7_2_r", m.rem, 32'hFFFF_FFFF);
        m = model(1'b1, 32'd7, 32'hFFFF_FFFE);
        chk("mdl_7_m2_q", m.quo, 32'hFFFF_FFFD);
        chk("mdl_7_m2_r", m.rem, 32'd1);
        m = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("mdl_ov_q", m.quo, 32'h8000_0000);
        chk("mdl_ov_r", m.rem, 32'd0);
        chk("mdl_ov_f", 32'(m.ov), 32'd1);

        run_op(1'b0, 32'd100, 32'd7, 0);
        chk("lit_100_7_q", quo, 32'd14);
        chk("lit_100_7_r", rem, 32'd2);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b0, 32'h1234_5678, 32'd0, 0);
        chk("lit_dz_q", quo, 32'hFFFF_FFFF);
        chk("lit_dz_f", 32'(dzflag), 32'd1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("lit_ov_f", 32'(ovflag), 32'd1);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("lit_uns_r", rem, 32'h8000_0000);

        run_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 10);
        run_op(1'b0, 32'd5, 32'd1, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra, rb;
            int k;
            k  = $urandom_range(0, 9);
            rb = (k == 0) ? 32'd0 : (k <= 3) ? 32'($urandom_range(1, 20)) :
                 (k == 4) ? 32'hFFFF_FFFF : $urandom;
            k  = $urandom_range(0, 9);
            ra = (k == 0) ? seq_div32_pkg::MIN : (k <= 2) ? 32'($urandom_range(0, 30)) : $urandom;
            run_op(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
        end

        sgn = 1'b0; A = 32'd1000; B = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        exp_r = model(1'b0, 32'd1000, 32'd3);
        cur_s = 1'b0; cur_a = 32'd1000; cur_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_quo", quo, 32'd0);
        chk("midrst_rem", rem, 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_flags", {30'd0, dzflag, ovflag}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, 32'd9, 32'd3, 0);
        chk("lit_9_3_q", quo, 32'd3);
        chk("lit_9_3_r", rem, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
